quad_phase_decoder: RTL and testbench
=====================================

QUAD_PHASE_DECODER -- requirements
Module: quad_phase_decoder

Interface
REQ-001 SHALL have parameter POS_W, default 16, width of the signed position counter.
REQ-002 SHALL have parameter FILT_LEN, default 4, number of consecutive stable cycles (1..255) a synchronized phase must hold before it is accepted.
REQ-003 SHALL have parameter PERIOD_W, default 24, width of the step-period measurement.
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have ports phase_a, phase_b  input  1 each  asynchronous quadrature phase inputs.
REQ-007 SHALL have port clear  input  1  synchronous position clear.
REQ-008 SHALL have port err_clr  input  1  clears the sticky error flag.
REQ-009 SHALL have port position  output  POS_W  signed two's-complement step count.
REQ-010 SHALL have port dir  output  1  direction of the last counted step (1 = forward).
REQ-011 SHALL have port step_valid  output  1  one-cycle pulse per counted step.
REQ-012 SHALL have port err  output  1  sticky illegal-transition flag.
REQ-013 SHALL have port period  output  PERIOD_W  sys_clk cycles between the last two same-direction steps.
REQ-014 SHALL have port period_valid  output  1  one-cycle pulse when period updates.
REQ-015 SHALL have port stalled  output  1  high while the step-interval counter is saturated.

Function
REQ-016 SHALL pass each phase input through a 2-flop synchronizer.
REQ-017 SHALL filter each synchronized phase: a per-phase stability counter restarts on any change and the filtered value takes the synchronized value once it has been stable for FILT_LEN cycles.
REQ-018 SHALL, after reset, load the first filtered {A,B} pair as the reference state with no step, no error and no period update (priming), then set a primed flag.
REQ-019 SHALL decode the filtered pair {A,B} in Gray order 00->01->11->10->00 as forward (+1, dir=1) and the reverse order as backward (-1, dir=0).
REQ-020 SHALL treat a two-bit change (00<->11, 01<->10) as illegal: set err, leave position and dir unchanged, adopt the new state as reference, and emit no step_valid.
REQ-021 SHALL update position, dir and step_valid one cycle after the filtered state changes; total latency from the first sys_clk edge sampling a new stable level to position update is FILT_LEN+3 cycles.
REQ-022 SHALL wrap position modulo 2^POS_W (0x7FFF+1 -> 0x8000, 0x0000-1 -> 0xFFFF for POS_W=16).
REQ-023 SHALL set position to 0 on the cycle after clear; clear together with a step yields 0 and still pulses step_valid and updates dir.
REQ-024 SHALL give err set priority over err_clr in the same cycle.
REQ-025 SHALL run an interval counter that resets to 0 on every counted step, otherwise increments and saturates at all-ones.
REQ-026 SHALL, on a step in the same direction as the previous counted step, load period with counter+1 (saturating at all-ones) and pulse period_valid; steps on consecutive cycles give period=1.
REQ-027 SHALL not pulse period_valid on the first step after reset or on a direction reversal; the counter still restarts.
REQ-028 SHALL drive stalled high while the interval counter equals all-ones and low on the cycle after the next counted step.

Reset
REQ-029 SHALL, while sys_rst_n is low at a clock edge, set position=0, dir=0, step_valid=0, err=0, period=0, period_valid=0, stalled=0, clear all filter counters, synchronizers and the interval counter, and clear the primed flag.
REQ-030 SHALL, on reset mid-sequence, discard any partially filtered level and re-prime from the input levels present after reset.

Verification
REQ-031 SHALL show: inputs 11 held through reset release -> after priming, position=0, err=0, no step_valid.
REQ-032 SHALL show: four forward Gray transitions 100 cycles apart, FILT_LEN=4 -> position=4, dir=1, three period_valid pulses each with period=100, each update 7 cycles after the input edge.
REQ-033 SHALL show: a glitch on phase_a lasting 3 cycles -> no step_valid and position unchanged.
REQ-034 SHALL show: 00->11 jump -> err=1, position unchanged; err_clr with no new error -> err=0 next cycle.
REQ-035 SHALL show: position=0x7FFF plus one forward step -> 0x8000; then one backward step -> 0x7FFF, dir=0, no period_valid.
REQ-036 SHALL show: no edges for 2^PERIOD_W cycles -> stalled=1; the next step -> stalled=0, period=all-ones with period_valid=1 if same direction.

Source files
------------

// File: rtl/quad_phase_decoder.sv
// -----------------------------------------------------------------------------
// quad_phase_decoder
//
// Decodes a pair of asynchronous quadrature phase inputs into a signed step
// count. It also reports the direction of the last step, flags illegal
// (two-bit) transitions and measures the time between same-direction steps.
//
// Processing chain (all on the rising edge of sys_clk):
//   phase_a/b -> 2-flop synchronizer -> per-phase stability filter
//             -> Gray decoder (reference vs filtered pair) -> position / dir /
//                step_valid / err, plus an interval counter -> period /
//                period_valid / stalled
//
// Ports
//   sys_clk       in   1         single clock, rising edge
//   sys_rst_n     in   1         reset, synchronous, active-low
//   phase_a       in   1         quadrature phase A (asynchronous)
//   phase_b       in   1         quadrature phase B (asynchronous)
//   clear         in   1         synchronous position clear
//   err_clr       in   1         clears the sticky error flag
//   position      out  POS_W     two's-complement step count (wraps)
//   dir           out  1         direction of last counted step, 1 = forward
//   step_valid    out  1         one-cycle pulse per counted step
//   err           out  1         sticky illegal-transition flag
//   period        out  PERIOD_W  cycles between the last two same-dir steps
//   period_valid  out  1         one-cycle pulse when period is updated
//   stalled       out  1         interval counter is saturated
//
// Parameters
//   POS_W     width of the position counter
//   FILT_LEN  cycles (1..255) a synchronized phase must be stable to be used
//   PERIOD_W  width of the interval counter / period output (>= 2)
// -----------------------------------------------------------------------------
module quad_phase_decoder #(
  parameter int POS_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                phase_a,
  input  logic                phase_b,
  input  logic                clear,
  input  logic                err_clr,
  output logic [POS_W-1:0]    position,
  output logic                dir,
  output logic                step_valid,
  output logic                err,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled
);

  // Stability counters are sized for the largest allowed FILT_LEN (255).
  localparam int                 CNT_W    = 8;
  localparam logic [CNT_W-1:0]   FILT_MAX = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]   STAB_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]   POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] PER_MAX = {PERIOD_W{1'b1}};

  // Maps a Gray-coded {A,B} pair onto its position in the forward cycle
  // 00 -> 01 -> 11 -> 10, so a forward step is always +1 modulo 4.
  function automatic logic [1:0] gray_to_idx(input logic [1:0] ab);
    gray_to_idx = {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Index 1 carries phase A, index 0 carries phase B, so a pair reads {A,B}.
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       last_q;
  logic [2:0]       vld_q;

  logic [CNT_W-1:0] stab_q [2];
  logic [CNT_W-1:0] stab_d [2];
  logic [1:0]       filt_q;
  logic [1:0]       filt_d;
  logic [1:0]       filt_ok_q;
  logic [1:0]       filt_ok_d;

  logic             primed_q;
  logic             primed_d;
  logic [1:0]       ref_q;
  logic [1:0]       ref_d;
  logic             have_dir_q;
  logic             have_dir_d;

  logic [1:0]       delta_s;
  logic             step_fwd_s;
  logic             step_bwd_s;
  logic             illegal_s;
  logic             step_s;
  logic             per_upd_s;

  logic [POS_W-1:0]    position_q;
  logic [POS_W-1:0]    position_d;
  logic                dir_q;
  logic                dir_d;
  logic                step_valid_q;
  logic                err_q;
  logic                err_d;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_d;
  logic                period_valid_q;
  logic [PERIOD_W-1:0] iv_q;
  logic [PERIOD_W-1:0] iv_d;
  logic                stalled_q;
  logic                stalled_d;

  // Two-flop synchronizer plus one history stage used for change detection.
  // vld_q marks which stages hold a sample taken after reset, so the reset
  // contents of the synchronizer are never accepted as a real level.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      last_q  <= 2'b00;
      vld_q   <= 3'b000;
    end else begin
      sync1_q <= {phase_a, phase_b};
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  // Per-phase stability filter: any change (or a not-yet-valid history)
  // restarts the counter; after FILT_LEN consecutive stable cycles the
  // synchronized level is copied into the filtered value.
  always_comb begin
    filt_d    = filt_q;
    filt_ok_d = filt_ok_q;
    for (int p = 0; p < 2; p++) begin
      stab_d[p] = stab_q[p];
      if (!vld_q[2] || (sync2_q[p] != last_q[p])) begin
        stab_d[p] = {CNT_W{1'b0}};
      end else if (stab_q[p] < FILT_MAX) begin
        stab_d[p] = stab_q[p] + STAB_ONE;
      end else begin
        filt_d[p]    = sync2_q[p];
        filt_ok_d[p] = 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int p = 0; p < 2; p++) begin
        stab_q[p] <= {CNT_W{1'b0}};
      end
      filt_q    <= 2'b00;
      filt_ok_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        stab_q[p] <= stab_d[p];
      end
      filt_q    <= filt_d;
      filt_ok_q <= filt_ok_d;
    end
  end

  // Gray decode of the filtered pair against the reference pair.
  always_comb begin
    delta_s    = gray_to_idx(filt_q) - gray_to_idx(ref_q);
    step_fwd_s = 1'b0;
    step_bwd_s = 1'b0;
    illegal_s  = 1'b0;
    if (primed_q) begin
      case (delta_s)
        2'd1:    step_fwd_s = 1'b1;
        2'd3:    step_bwd_s = 1'b1;
        2'd2:    illegal_s  = 1'b1;
        default: step_fwd_s = 1'b0;
      endcase
    end else begin
      step_fwd_s = 1'b0;
    end
    step_s    = step_fwd_s | step_bwd_s;
    // A period is only meaningful between two steps of the same direction.
    per_upd_s = step_s & have_dir_q & (step_fwd_s == dir_q);
  end

  // Next-state for the reference pair and the counting outputs.
  always_comb begin
    // The first pair accepted by both filters becomes the reference without
    // counting; from then on the reference follows the filtered pair.
    if (primed_q || (&filt_ok_q)) begin
      ref_d = filt_q;
    end else begin
      ref_d = ref_q;
    end
    primed_d   = primed_q | (&filt_ok_q);
    have_dir_d = have_dir_q | step_s;

    // Clear wins over a simultaneous step; dir and step_valid still follow it.
    if (clear) begin
      position_d = {POS_W{1'b0}};
    end else if (step_fwd_s) begin
      position_d = position_q + POS_ONE;
    end else if (step_bwd_s) begin
      position_d = position_q - POS_ONE;
    end else begin
      position_d = position_q;
    end

    if (step_s) begin
      dir_d = step_fwd_s;
    end else begin
      dir_d = dir_q;
    end

    // A new error takes priority over err_clr.
    if (illegal_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Interval counter measures cycles since the last counted step.
    if (step_s) begin
      iv_d = {PERIOD_W{1'b0}};
    end else if (iv_q == PER_MAX) begin
      iv_d = iv_q;
    end else begin
      iv_d = iv_q + PER_ONE;
    end

    // The step edge itself is one cycle after the last counter value.
    if (per_upd_s) begin
      if (iv_q == PER_MAX) begin
        period_d = PER_MAX;
      end else begin
        period_d = iv_q + PER_ONE;
      end
    end else begin
      period_d = period_q;
    end

    stalled_d = (iv_d == PER_MAX);
  end

  // Decoder and measurement registers, including all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      primed_q       <= 1'b0;
      ref_q          <= 2'b00;
      have_dir_q     <= 1'b0;
      position_q     <= {POS_W{1'b0}};
      dir_q          <= 1'b0;
      step_valid_q   <= 1'b0;
      err_q          <= 1'b0;
      period_q       <= {PERIOD_W{1'b0}};
      period_valid_q <= 1'b0;
      iv_q           <= {PERIOD_W{1'b0}};
      stalled_q      <= 1'b0;
    end else begin
      primed_q       <= primed_d;
      ref_q          <= ref_d;
      have_dir_q     <= have_dir_d;
      position_q     <= position_d;
      dir_q          <= dir_d;
      step_valid_q   <= step_s;
      err_q          <= err_d;
      period_q       <= period_d;
      period_valid_q <= per_upd_s;
      iv_q           <= iv_d;
      stalled_q      <= stalled_d;
    end
  end

  assign position     = position_q;
  assign dir          = dir_q;
  assign step_valid   = step_valid_q;
  assign err          = err_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_quad_phase_decoder.sv
// Self-checking bench for quad_phase_decoder: directed scenarios plus a
// randomized phase walk, every cycle compared against a behavioural model.
module tb_quad_phase_decoder;

  localparam int POS_W    = 8;
  localparam int FILT_LEN = 4;
  localparam int PERIOD_W = 8;
  localparam int PMOD     = 1 << POS_W;
  localparam int PMAX     = (1 << PERIOD_W) - 1;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic                phase_a;
  logic                phase_b;
  logic                clear;
  logic                err_clr;
  logic [POS_W-1:0]    position;
  logic                dir;
  logic                step_valid;
  logic                err;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                stalled;

  quad_phase_decoder #(
    .POS_W   (POS_W),
    .FILT_LEN(FILT_LEN),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .phase_a     (phase_a),
    .phase_b     (phase_b),
    .clear       (clear),
    .err_clr     (err_clr),
    .position    (position),
    .dir         (dir),
    .step_valid  (step_valid),
    .err         (err),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int sv_cnt = 0;
  int pv_cnt = 0;
  int last_per = 0;
  int cur_ab = 0;

  // Forward order of {A,B} values.
  int gray_ord [4] = '{0, 1, 3, 2};

  // Reference model state.
  int m_pos, m_per, m_iv, m_ref;
  bit m_dir, m_sv, m_err, m_pv, m_stl, m_primed, m_have;
  bit m_filt [2];
  bit m_ok [2];
  bit hist_a [$];
  bit hist_b [$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ord_of(input int v);
    int o;
    o = 0;
    for (int i = 0; i < 4; i++) if (gray_ord[i] == v) o = i;
    return o;
  endfunction

  function automatic int next_ab(input int v, input bit fwd);
    int o;
    o = ord_of(v);
    return gray_ord[fwd ? (o + 1) % 4 : (o + 3) % 4];
  endfunction

  // True when samples lo..hi of a phase history all hold the same level.
  function automatic bit window_stable(input bit is_a, input int lo, input int hi);
    bit v0;
    v0 = is_a ? hist_a[lo] : hist_b[lo];
    for (int i = lo; i <= hi; i++) begin
      if ((is_a ? hist_a[i] : hist_b[i]) != v0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One rising edge of the model, given the inputs seen at that edge.
  task automatic model_edge(input bit a, input bit b, input bit cl, input bit ec, input bit rn);
    int cur, d, k;
    bit stp, fwd, bad;
    if (!rn) begin
      m_pos = 0; m_per = 0; m_iv = 0; m_ref = 0;
      m_dir = 0; m_sv = 0; m_err = 0; m_pv = 0; m_stl = 0;
      m_primed = 0; m_have = 0;
      m_filt[0] = 0; m_filt[1] = 0; m_ok[0] = 0; m_ok[1] = 0;
      hist_a.delete(); hist_b.delete();
      return;
    end
    stp = 0; fwd = 0; bad = 0; m_sv = 0; m_pv = 0;
    cur = (m_filt[1] ? 2 : 0) + (m_filt[0] ? 1 : 0);
    if (m_primed) begin
      d = (ord_of(cur) - ord_of(m_ref) + 4) % 4;
      if (d == 1 || d == 3) begin stp = 1; fwd = (d == 1); end
      else if (d == 2) bad = 1;
      m_ref = cur;
    end else if (m_ok[0] && m_ok[1]) begin
      m_ref = cur;
      m_primed = 1;
    end
    if (stp) begin
      if (m_have && fwd == m_dir) begin
        m_per = (m_iv + 1 > PMAX) ? PMAX : m_iv + 1;
        m_pv = 1;
      end
      m_have = 1; m_dir = fwd; m_sv = 1; m_iv = 0;
      m_pos = (m_pos + (fwd ? 1 : PMOD - 1)) % PMOD;
    end else begin
      m_iv = (m_iv < PMAX) ? m_iv + 1 : PMAX;
    end
    if (cl) m_pos = 0;
    if (bad) m_err = 1; else if (ec) m_err = 0;
    m_stl = (m_iv == PMAX);
    // A level is accepted once FILT_LEN+1 consecutive post-reset samples,
    // ending two edges ago (synchronizer delay), all agree.
    hist_a.push_back(a); hist_b.push_back(b);
    k = hist_a.size() - 1;
    if (k >= FILT_LEN + 2) begin
      if (window_stable(1'b1, k - FILT_LEN - 2, k - 2)) begin m_filt[1] = hist_a[k - 2]; m_ok[1] = 1; end
      if (window_stable(1'b0, k - FILT_LEN - 2, k - 2)) begin m_filt[0] = hist_b[k - 2]; m_ok[0] = 1; end
    end
  endtask

  // Advance one cycle: model the edge, then compare every output mid-cycle.
  task automatic tick();
    bit a, b, c, e, r;
    a = phase_a; b = phase_b; c = clear; e = err_clr; r = sys_rst_n;
    @(posedge sys_clk);
    model_edge(a, b, c, e, r);
    @(negedge sys_clk);
    check_val("position", int'(position), m_pos);
    check_val("dir", int'(dir), int'(m_dir));
    check_val("step_valid", int'(step_valid), int'(m_sv));
    check_val("err", int'(err), int'(m_err));
    check_val("period", int'(period), m_per);
    check_val("period_valid", int'(period_valid), int'(m_pv));
    check_val("stalled", int'(stalled), int'(m_stl));
    if (step_valid) sv_cnt++;
    if (period_valid) begin pv_cnt++; last_per = int'(period); end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_ab(input int v);
    phase_a = v[1];
    phase_b = v[0];
    cur_ab  = v;
  endtask

  // Drive a new pair, run n cycles, report edges from first sample to step.
  task automatic move(input int v, input int n, output int lat);
    drive_ab(v);
    lat = -1;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (step_valid && lat < 0) lat = t - 1;
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, got, s_stl, s_per, s_pv, r, n;
    sys_rst_n = 1'b0; clear = 1'b0; err_clr = 1'b0;
    drive_ab(3);

    // Inputs 11 held through reset release: primes silently.
    hold(3);
    check_val("reset_position", int'(position), 0);
    check_val("reset_period", int'(period), 0);
    sys_rst_n = 1'b1;
    sv_cnt = 0;
    hold(20);
    check_val("prime_position", int'(position), 0);
    check_val("prime_err", int'(err), 0);
    check_val("prime_no_step", sv_cnt, 0);

    // Four forward steps 100 cycles apart.
    sv_cnt = 0; pv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      move(next_ab(cur_ab, 1'b1), 100, lat);
      check_val("fwd_latency", lat, FILT_LEN + 3);
      check_val("fwd_pv_count", pv_cnt, i);
      if (i > 0) check_val("fwd_period", last_per, 100);
    end
    check_val("fwd_position", int'(position), 4);
    check_val("fwd_dir", int'(dir), 1);
    check_val("fwd_steps", sv_cnt, 4);

    // Three-cycle glitch on phase_a is filtered out.
    sv_cnt = 0;
    phase_a = ~phase_a;
    hold(3);
    phase_a = ~phase_a;
    hold(20);
    check_val("glitch_no_step", sv_cnt, 0);
    check_val("glitch_position", int'(position), 4);

    // Back to 00, then an illegal 00 -> 11 jump.
    move(next_ab(cur_ab, 1'b0), 12, lat);
    move(next_ab(cur_ab, 1'b0), 12, lat);
    check_val("bwd_position", int'(position), 2);
    sv_cnt = 0;
    drive_ab(3);
    hold(12);
    check_val("jump_err", int'(err), 1);
    check_val("jump_position", int'(position), 2);
    check_val("jump_no_step", sv_cnt, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("err_cleared", int'(err), 0);

    // Wrap 0x7F -> 0x80 -> 0x7F.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("clear_position", int'(position), 0);
    for (int i = 0; i < 127; i++) move(next_ab(cur_ab, 1'b1), 8, lat);
    check_val("wrap_pre", int'(position), 127);
    move(next_ab(cur_ab, 1'b1), 8, lat);
    check_val("wrap_up", int'(position), 128);
    pv_cnt = 0;
    move(next_ab(cur_ab, 1'b0), 8, lat);
    check_val("wrap_down", int'(position), 127);
    check_val("wrap_dir", int'(dir), 0);
    check_val("reversal_no_pv", pv_cnt, 0);

    // Stall, then a same-direction step reports a saturated period.
    hold(300);
    check_val("stall_high", int'(stalled), 1);
    drive_ab(next_ab(cur_ab, 1'b0));
    got = 0; s_stl = 1; s_per = 0; s_pv = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (step_valid && got == 0) begin
        got = 1; s_stl = int'(stalled); s_per = int'(period); s_pv = int'(period_valid);
      end
    end
    check_val("stall_step_seen", got, 1);
    check_val("stall_released", s_stl, 0);
    check_val("stall_period", s_per, PMAX);
    check_val("stall_pv", s_pv, 1);

    // Reset in the middle of filtering a new level.
    drive_ab(next_ab(cur_ab, 1'b1));
    hold(3);
    sys_rst_n = 1'b0;
    hold(2);
    sys_rst_n = 1'b1;
    sv_cnt = 0;
    hold(20);
    check_val("midrst_position", int'(position), 0);
    check_val("midrst_no_step", sv_cnt, 0);
    check_val("midrst_err", int'(err), 0);

    // Randomized walk: legal steps, illegal jumps, pauses, clears, resets.
    for (int it = 0; it < 2500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 42) drive_ab(next_ab(cur_ab, 1'b1));
      else if (r < 84) drive_ab(next_ab(cur_ab, 1'b0));
      else if (r < 92) drive_ab(cur_ab ^ 3);
      n = $urandom_range(1, 12);
      clear   = ($urandom_range(0, 24) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) sys_rst_n = 1'b0;
      tick();
      clear = 1'b0; err_clr = 1'b0; sys_rst_n = 1'b1;
      hold(n - 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
